pairing_dispatch: RTL and testbench

PAIRING_DISPATCH -- requirements
Module: pairing_dispatch

---
 rtl/pairing_dispatch.sv | 202 ++++++++++++++++++++
 tb/tb_pairing_dispatch.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pairing_dispatch.sv
// pairing_dispatch
//   Queues pairing requests in a small FIFO and launches them one at a time
//   into a single pairing engine, returning each result (or a watchdog error)
//   as a held response. At most one request is in flight; responses come back
//   in request order.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready reflects registered occupancy
//   req_mode, req_tag     0 = full Tate, 1 = Miller loop only; request identifier
//   req_x1..req_y2        operands (W bits each)
//   flush                 drop all queued, not-yet-launched requests
//   eng_start             one-cycle launch/reset pulse to the engine
//   eng_mode, eng_x1..    launched mode and operands, stable until next launch
//   eng_done, eng_out     engine result strobe and 6*W-bit result
//   rsp_valid/rsp_ready   response handshake
//   rsp_tag, rsp_mode     identity of the responded request
//   rsp_err, rsp_out      watchdog-expiry flag; result (zero when rsp_err)
//   busy                  FSM not idle or FIFO non-empty
//   q_count               FIFO occupancy, 0..DEPTH
module pairing_dispatch #(
    parameter int W       = 194,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_mode,
    input  logic [TAGW-1:0]          req_tag,
    input  logic [W-1:0]             req_x1,
    input  logic [W-1:0]             req_y1,
    input  logic [W-1:0]             req_x2,
    input  logic [W-1:0]             req_y2,
    input  logic                     flush,
    output logic                     eng_start,
    output logic                     eng_mode,
    output logic [W-1:0]             eng_x1,
    output logic [W-1:0]             eng_y1,
    output logic [W-1:0]             eng_x2,
    output logic [W-1:0]             eng_y2,
    input  logic                     eng_done,
    input  logic [6*W-1:0]           eng_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [TAGW-1:0]          rsp_tag,
    output logic                     rsp_mode,
    output logic                     rsp_err,
    output logic [6*W-1:0]           rsp_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int EW  = 1 + TAGW + 4 * W;
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]    FULL    = (AW + 1)'(DEPTH);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t          state, state_next;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [WDW-1:0]  wd_cnt;
    logic [TAGW-1:0] run_tag;
    logic [EW-1:0]   head;

    logic            push;
    logic            launch;
    logic            done_take;
    logic            timeout;

    assign req_ready = (q_count != FULL);
    // flush wins over a same-cycle push
    assign push      = req_valid && req_ready && !flush;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (q_count != '0);

    // Next-state and event decode
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        done_take  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && (q_count != '0)) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // eng_done in the eng_start cycle belongs to the previous
                // engine run, so it is not taken as this request's result
                if (eng_done && !eng_start) begin
                    done_take  = 1'b1;
                    state_next = HOLD;
                end else if (wd_cnt == WD_LAST) begin
                    timeout    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage; contents are meaningless once pointers are reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_mode, req_tag, req_x1, req_y1, req_x2, req_y2};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            wd_cnt    <= '0;
            run_tag   <= '0;
            eng_start <= 1'b0;
            eng_mode  <= 1'b0;
            eng_x1    <= '0;
            eng_y1    <= '0;
            eng_x2    <= '0;
            eng_y2    <= '0;
            rsp_valid <= 1'b0;
            rsp_tag   <= '0;
            rsp_mode  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_out   <= '0;
        end else begin
            state     <= state_next;
            eng_start <= 1'b0;

            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                q_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (launch) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, launch})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: ;
                endcase
            end

            if (launch) begin
                {eng_mode, run_tag, eng_x1, eng_y1, eng_x2, eng_y2} <= head;
                eng_start <= 1'b1;
                wd_cnt    <= '0;
            end else if (state == RUN && !timeout) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (done_take) begin
                rsp_valid <= 1'b1;
                rsp_tag   <= run_tag;
                rsp_mode  <= eng_mode;
                rsp_err   <= 1'b0;
                rsp_out   <= eng_out;
            end

            // Expiry answers with an error and re-pulses eng_start so the
            // engine is reset before the next request is launched
            if (timeout) begin
                rsp_valid <= 1'b1;
                rsp_tag   <= run_tag;
                rsp_mode  <= eng_mode;
                rsp_err   <= 1'b1;
                rsp_out   <= '0;
                eng_start <= 1'b1;
            end

            if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pairing_dispatch.sv
// tb_pairing_dispatch
//   Directed bench for pairing_dispatch. u_dut (W=8, DEPTH=4, TIMEOUT=200)
//   covers dispatch, fill, back-pressure, flush and reset; u_wd (TIMEOUT=16,
//   engine never done) shares the stimulus and covers watchdog expiry.
module tb_pairing_dispatch;

    localparam int W  = 8;
    localparam int RW = 6 * W;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_mode;
    logic [3:0]    req_tag;
    logic [W-1:0]  req_x1, req_y1, req_x2, req_y2;
    logic          flush;
    logic          eng_done;
    logic [RW-1:0] eng_out;
    logic          rsp_ready;

    logic          a_req_ready, a_eng_start, a_eng_mode, a_rsp_valid, a_rsp_mode, a_rsp_err, a_busy;
    logic [W-1:0]  a_eng_x1, a_eng_y1, a_eng_x2, a_eng_y2;
    logic [3:0]    a_rsp_tag;
    logic [RW-1:0] a_rsp_out;
    logic [2:0]    a_q_count;

    logic          w_req_ready, w_eng_start, w_eng_mode, w_rsp_valid, w_rsp_mode, w_rsp_err, w_busy;
    logic [W-1:0]  w_eng_x1, w_eng_y1, w_eng_x2, w_eng_y2;
    logic [3:0]    w_rsp_tag;
    logic [RW-1:0] w_rsp_out;
    logic [2:0]    w_q_count;

    int nchk = 0;
    int nbad = 0;

    pairing_dispatch #(.W(W), .DEPTH(4), .TAGW(4), .TIMEOUT(200)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_mode(req_mode), .req_tag(req_tag),
        .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
        .flush(flush),
        .eng_start(a_eng_start), .eng_mode(a_eng_mode),
        .eng_x1(a_eng_x1), .eng_y1(a_eng_y1), .eng_x2(a_eng_x2), .eng_y2(a_eng_y2),
        .eng_done(eng_done), .eng_out(eng_out),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(a_rsp_tag),
        .rsp_mode(a_rsp_mode), .rsp_err(a_rsp_err), .rsp_out(a_rsp_out),
        .busy(a_busy), .q_count(a_q_count)
    );

    pairing_dispatch #(.W(W), .DEPTH(4), .TAGW(4), .TIMEOUT(16)) u_wd (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(w_req_ready), .req_mode(req_mode), .req_tag(req_tag),
        .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
        .flush(flush),
        .eng_start(w_eng_start), .eng_mode(w_eng_mode),
        .eng_x1(w_eng_x1), .eng_y1(w_eng_y1), .eng_x2(w_eng_x2), .eng_y2(w_eng_y2),
        .eng_done(1'b0), .eng_out(eng_out),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(w_rsp_tag),
        .rsp_mode(w_rsp_mode), .rsp_err(w_rsp_err), .rsp_out(w_rsp_out),
        .busy(w_busy), .q_count(w_q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] op(input logic [3:0] t, input int k);
        return {t, 4'(k)};
    endfunction

    function automatic logic [RW-1:0] pat(input logic [3:0] t);
        return {40'hC0FFEE1234, 4'h5, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] t, input logic m);
        req_tag  = t;
        req_mode = m;
        req_x1   = op(t, 1);
        req_y1   = op(t, 2);
        req_x2   = op(t, 3);
        req_y2   = op(t, 4);
    endtask

    task automatic push_one(input logic [3:0] t, input logic m);
        set_req(t, m);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic await_launch(input string tag);
        int n = 0;
        while (a_eng_start !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, RW'(n < 100), RW'(1));
    endtask

    // Wait for launch of tag t, answer it, then consume the response.
    // early=1 raises eng_done already in the eng_start cycle.
    task automatic serve(input logic [3:0] t, input logic early);
        await_launch("launch_seen");
        check("srv_x1", a_eng_x1, op(t, 1));
        check("srv_y2", a_eng_y2, op(t, 4));
        if (early) begin
            eng_done = 1'b1;
            eng_out  = pat(t);
            tick();
            check("done_at_start_ignored", a_rsp_valid, 1'b0);
            tick();
            eng_done = 1'b0;
        end else begin
            tick();
            tick();
            eng_done = 1'b1;
            eng_out  = pat(t);
            tick();
            eng_done = 1'b0;
        end
        check("srv_valid", a_rsp_valid, 1'b1);
        check("srv_tag", a_rsp_tag, t);
        check("srv_out", a_rsp_out, pat(t));
        check("srv_err", a_rsp_err, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("srv_release", a_rsp_valid, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic ok;
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0; eng_done = 1'b0;
        eng_out = '0; rsp_ready = 1'b0;
        set_req(4'd0, 1'b0);
        tick(); tick(); tick();
        reset = 1'b0;

        // reset state
        check("rst_rsp_valid", a_rsp_valid, 1'b0);
        check("rst_eng_start", a_eng_start, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_q_count", a_q_count, 3'd0);
        check("rst_req_ready", a_req_ready, 1'b1);
        check("rst_eng_x1", a_eng_x1, '0);
        check("rst_rsp_out", a_rsp_out, '0);

        // single request, engine answers 40 cycles after eng_start
        push_one(4'd3, 1'b0);
        check("t1_no_start_yet", a_eng_start, 1'b0);
        check("t1_q1", a_q_count, 3'd1);
        tick();
        check("t1_start_at_2", a_eng_start, 1'b1);
        check("t1_x1", a_eng_x1, op(4'd3, 1));
        check("t1_y1", a_eng_y1, op(4'd3, 2));
        check("t1_x2", a_eng_x2, op(4'd3, 3));
        check("t1_y2", a_eng_y2, op(4'd3, 4));
        check("t1_mode", a_eng_mode, 1'b0);
        check("t1_q0", a_q_count, 3'd0);
        check("t1_busy", a_busy, 1'b1);
        tick();
        check("t1_start_one_cycle", a_eng_start, 1'b0);
        repeat (38) tick();
        eng_done = 1'b1;
        eng_out  = pat(4'd3);
        tick();
        eng_done = 1'b0;
        eng_out  = '0;
        check("t1_rsp_valid", a_rsp_valid, 1'b1);
        check("t1_rsp_tag", a_rsp_tag, 4'd3);
        check("t1_rsp_out", a_rsp_out, pat(4'd3));
        check("t1_rsp_err", a_rsp_err, 1'b0);
        check("t1_rsp_mode", a_rsp_mode, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_released", a_rsp_valid, 1'b0);
        check("t1_idle", a_busy, 1'b0);

        // fill the FIFO while a response is held, then back-pressure
        push_one(4'd5, 1'b1);
        await_launch("t2_launch5");
        tick(); tick();
        eng_done = 1'b1;
        eng_out  = pat(4'd5);
        tick();
        eng_done = 1'b0;
        eng_out  = '0;
        check("t2_hold_tag", a_rsp_tag, 4'd5);
        check("t2_hold_mode", a_rsp_mode, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(4'(6 + i), 1'b0);
            req_valid = 1'b1;
            if (a_req_ready !== 1'b1) ok = 1'b0;
            tick();
        end
        check("t2_fill_ready", ok, 1'b1);
        set_req(4'd10, 1'b0);
        check("t2_full_count", a_q_count, 3'd4);
        check("t2_full_not_ready", a_req_ready, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (a_rsp_valid !== 1'b1 || a_rsp_tag !== 4'd5 || a_rsp_out !== pat(4'd5) ||
                a_eng_start !== 1'b0 || a_q_count !== 3'd4) ok = 1'b0;
        end
        check("t2_hold_stable", ok, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t2_idle_return", a_rsp_valid, 1'b0);
        check("t2_no_start_in_hold", a_eng_start, 1'b0);
        check("t2_still_full", a_q_count, 3'd4);
        tick();
        check("t2_resume_start", a_eng_start, 1'b1);
        check("t2_resume_x1", a_eng_x1, op(4'd6, 1));
        check("t2_pop_no_push", a_q_count, 3'd3);
        tick();
        req_valid = 1'b0;
        check("t2_fifth_accepted", a_q_count, 3'd4);
        // tag 6 already launched
        tick();
        eng_done = 1'b1;
        eng_out  = pat(4'd6);
        tick();
        eng_done = 1'b0;
        check("t2_rsp6_tag", a_rsp_tag, 4'd6);
        check("t2_rsp6_out", a_rsp_out, pat(4'd6));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        serve(4'd7, 1'b1);
        serve(4'd8, 1'b0);
        serve(4'd9, 1'b0);
        serve(4'd10, 1'b0);
        check("t2_drained", a_busy, 1'b0);

        // watchdog on u_wd (TIMEOUT=16)
        do_reset();
        push_one(4'd12, 1'b0);
        push_one(4'd13, 1'b1);
        check("wd_start1", w_eng_start, 1'b1);
        check("wd_x1", w_eng_x1, op(4'd12, 1));
        repeat (15) tick();
        check("wd_not_yet", w_rsp_valid, 1'b0);
        tick();
        check("wd_rsp_valid", w_rsp_valid, 1'b1);
        check("wd_rsp_err", w_rsp_err, 1'b1);
        check("wd_rsp_out", w_rsp_out, '0);
        check("wd_rsp_tag", w_rsp_tag, 4'd12);
        check("wd_restart_pulse", w_eng_start, 1'b1);
        tick();
        check("wd_restart_one_cycle", w_eng_start, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("wd_released", w_rsp_valid, 1'b0);
        check("wd_no_start_idle", w_eng_start, 1'b0);
        tick();
        check("wd_next_start", w_eng_start, 1'b1);
        check("wd_next_x1", w_eng_x1, op(4'd13, 1));
        check("wd_next_mode", w_eng_mode, 1'b1);

        // flush with a coincident push, one request in flight
        do_reset();
        push_one(4'd1, 1'b0);
        push_one(4'd2, 1'b0);
        push_one(4'd3, 1'b0);
        push_one(4'd4, 1'b0);
        check("fl_queued3", a_q_count, 3'd3);
        set_req(4'd5, 1'b0);
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fl_count0", a_q_count, 3'd0);
        check("fl_busy_inflight", a_busy, 1'b1);
        check("fl_eng_x1_kept", a_eng_x1, op(4'd1, 1));
        tick();
        eng_done = 1'b1;
        eng_out  = pat(4'd1);
        tick();
        eng_done = 1'b0;
        check("fl_inflight_tag", a_rsp_tag, 4'd1);
        check("fl_inflight_valid", a_rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_eng_start !== 1'b0 || a_q_count !== 3'd0) ok = 1'b0;
        end
        check("fl_push_dropped", ok, 1'b1);
        check("fl_idle", a_busy, 1'b0);

        // reset mid-RUN, then a late eng_done
        push_one(4'd7, 1'b1);
        tick();
        tick();
        check("rr_running", a_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        eng_done = 1'b1;
        eng_out  = pat(4'd7);
        tick();
        eng_done = 1'b0;
        check("rr_rsp_valid", a_rsp_valid, 1'b0);
        check("rr_eng_start", a_eng_start, 1'b0);
        check("rr_busy", a_busy, 1'b0);
        check("rr_q_count", a_q_count, 3'd0);
        check("rr_eng_x1", a_eng_x1, '0);
        check("rr_eng_mode", a_eng_mode, 1'b0);
        check("rr_rsp_out", a_rsp_out, '0);
        check("rr_rsp_tag", a_rsp_tag, 4'd0);
        repeat (3) tick();
        check("rr_still_quiet", a_rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
